// File: rtl/diff_window_accumulator.sv
// Accumulates a window of unsigned difference samples and reports sum, count, max and min.
// Windows close on the WIN-th sample or on an early flush; results are held until the consumer handshakes.
module diff_window_accumulator #(
  parameter int DW  = 4,
  parameter int WIN = 4,
  parameter int CW  = $clog2(WIN + 1),
  parameter int SW  = DW + $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_diff,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic [DW-1:0] out_max,
  output logic [DW-1:0] out_min
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        r_state;
  logic [SW-1:0] r_acc_sum;
  logic [CW-1:0] r_acc_cnt;
  logic [DW-1:0] r_acc_max;
  logic [DW-1:0] r_acc_min;
  logic          r_out_valid;
  logic [SW-1:0] r_out_sum;
  logic [CW-1:0] r_out_count;
  logic [DW-1:0] r_out_max;
  logic [DW-1:0] r_out_min;

  logic          w_accept;
  logic          w_close;
  logic [SW-1:0] w_sum_next;
  logic [CW-1:0] w_cnt_next;
  logic [DW-1:0] w_max_next;
  logic [DW-1:0] w_min_next;

  // Combinational so that ready drops with reset and rises in the first cycle after release.
  assign in_ready = ~rst & (r_state == ACCUM);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_sum_next = r_acc_sum;
    w_cnt_next = r_acc_cnt;
    w_max_next = r_acc_max;
    w_min_next = r_acc_min;
    if (w_accept) begin
      w_sum_next = r_acc_sum + SW'(in_diff);
      w_cnt_next = r_acc_cnt + CW'(1);
      if (r_acc_cnt == '0) begin
        w_max_next = in_diff;
        w_min_next = in_diff;
      end else begin
        w_max_next = (in_diff > r_acc_max) ? in_diff : r_acc_max;
        w_min_next = (in_diff < r_acc_min) ? in_diff : r_acc_min;
      end
    end
    w_close = (r_state == ACCUM) &&
              ((w_accept && (w_cnt_next == CW'(WIN))) || (flush && (w_cnt_next != '0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc_sum   <= '0;
      r_acc_cnt   <= '0;
      r_acc_max   <= '0;
      r_acc_min   <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_max   <= '0;
      r_out_min   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_close) begin
            r_out_sum   <= w_sum_next;
            r_out_count <= w_cnt_next;
            r_out_max   <= w_max_next;
            r_out_min   <= w_min_next;
            r_out_valid <= 1'b1;
            r_acc_sum   <= '0;
            r_acc_cnt   <= '0;
            r_acc_max   <= '0;
            r_acc_min   <= '0;
            r_state     <= HOLD;
          end else begin
            r_acc_sum <= w_sum_next;
            r_acc_cnt <= w_cnt_next;
            r_acc_max <= w_max_next;
            r_acc_min <= w_min_next;
          end
        end
        HOLD: begin
          // Accumulators were cleared on entry, so leaving HOLD only drops valid.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_max   = r_out_max;
  assign out_min   = r_out_min;

endmodule

// File: tb/tb_diff_window_accumulator.sv
// Directed bench for diff_window_accumulator with WIN=4, DW=4.
// Result bundle compared as {valid, sum, count, max, min} against hand-computed values.
module tb_diff_window_accumulator;
  localparam int DW  = 4;
  localparam int WIN = 4;
  localparam int CW  = 3;
  localparam int SW  = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_diff;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic [DW-1:0] out_max;
  logic [DW-1:0] out_min;

  int total = 0;
  int bad   = 0;

  logic [18:0] obs;

  diff_window_accumulator #(.DW(DW), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_max(out_max), .out_min(out_min)
  );

  always #5 clk = ~clk;

  always_comb obs = {out_valid, out_sum, out_count, out_max, out_min};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_diff  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_diff = '0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    total++;
    if ({in_ready, obs} !== {1'b0, 19'd0}) begin
      bad++; $display("FAIL reset_state got %h want %h", {in_ready, obs}, {1'b0, 19'd0});
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_window();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_diff = 4'd12; cyc();
    in_diff = 4'd0;  cyc();
    in_diff = 4'd3;  cyc();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL full_early_valid got %b want 0", out_valid);
    end
    in_diff = 4'd5;  cyc();
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 7'd20, 3'd4, 4'd12, 4'd0}) begin
      bad++; $display("FAIL full_window got %h want %h", obs, {1'b1, 7'd20, 3'd4, 4'd12, 4'd0});
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL full_hold_ready got %b want 0", in_ready);
    end
    cyc();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL full_release got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_overflow_bound();
    in_valid = 1'b1;
    in_diff = 4'd15;
    cyc(); cyc(); cyc(); cyc();
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 7'd60, 3'd4, 4'd15, 4'd15}) begin
      bad++; $display("FAIL overflow_bound got %h want %h", obs, {1'b1, 7'd60, 3'd4, 4'd15, 4'd15});
    end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    in_valid = 1'b1;
    in_diff  = 4'd9;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({in_ready, obs} !== {1'b0, 1'b1, 7'd10, 3'd4, 4'd4, 4'd1}) begin
        bad++;
        $display("FAIL backpressure_hold%0d got %h want %h", i, {in_ready, obs},
                 {1'b0, 1'b1, 7'd10, 3'd4, 4'd4, 4'd1});
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL backpressure_release got %b want 01", {out_valid, in_ready});
    end
    cyc();
    in_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    total++;
    if (obs !== {1'b1, 7'd9, 3'd1, 4'd9, 4'd9}) begin
      bad++; $display("FAIL backpressure_next got %h want %h", obs, {1'b1, 7'd9, 3'd1, 4'd9, 4'd9});
    end
    cyc();
  endtask

  task automatic test_flush();
    send(4'd7); send(4'd9);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    total++;
    if (obs !== {1'b1, 7'd16, 3'd2, 4'd9, 4'd7}) begin
      bad++; $display("FAIL early_flush got %h want %h", obs, {1'b1, 7'd16, 3'd2, 4'd9, 4'd7});
    end
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL empty_flush got %b want 01", {out_valid, in_ready});
    end
    cyc();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL empty_flush_late got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush_with_sample();
    send(4'd2); send(4'd3);
    in_valid = 1'b1; in_diff = 4'd4; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (obs !== {1'b1, 7'd9, 3'd3, 4'd4, 4'd2}) begin
      bad++; $display("FAIL flush_with_sample got %h want %h", obs, {1'b1, 7'd9, 3'd3, 4'd4, 4'd2});
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    send(4'd14); send(4'd2);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, obs} !== {1'b0, 19'd0}) begin
      bad++; $display("FAIL reset_mid got %h want %h", {in_ready, obs}, {1'b0, 19'd0});
    end
    cyc();
    rst = 1'b0;
    #1;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    total++;
    if (obs !== {1'b1, 7'd4, 3'd4, 4'd1, 4'd1}) begin
      bad++; $display("FAIL reset_residue got %h want %h", obs, {1'b1, 7'd4, 3'd4, 4'd1, 4'd1});
    end
    out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 19'd0) begin
      bad++; $display("FAIL reset_in_hold got %h want %h", obs, 19'd0);
    end
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_overflow_bound();
    test_backpressure();
    test_flush();
    test_flush_with_sample();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
